decode: RTL and testbench

- Single-cycle decode/execute unit for RV32I integer ALU instructions.
- Accepts one 32-bit instruction word per clock.
- Reads operands from an internal 32-entry register file, computes the ALU result, writes it back to rd, and presents it on a registered output.
- Sits between instruction fetch and the rest of the datapath; contains its own register file (regfile-style, 2 read, 1 write).

---
 rtl/decode.sv | 139 +++++++++++++
 tb/tb_decode.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode -- single-cycle RV32I integer ALU decode/execute unit.
//
// One instruction word is sampled on every rising clock edge. Operands come
// combinationally from an internal 32 x N register file (2 read, 1 write);
// the ALU value is written back to rd and presented on a registered output.
// A dependent instruction on the next cycle sees the updated register.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous, active-high reset
//   opcode   in   32  RV32 instruction word
//   result   out  N   registered ALU result of the last executed instruction
//   illegal  out  1   registered; 1 when the last sampled word was unsupported
//
// Build option:
//   REG_SEED_EN  defined   -> reset loads xi with i (x0 stays 0)
//                undefined -> reset clears every register to 0
// -----------------------------------------------------------------------------
module decode #(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   opcode,
  output logic [N-1:0]  result,
  output logic          illegal
);

  localparam logic [6:0] MAJ_OP     = 7'b0110011;
  localparam logic [6:0] MAJ_OP_IMM = 7'b0010011;
  localparam logic [6:0] MAJ_LUI    = 7'b0110111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [N-1:0] regs_q [32];
  logic [N-1:0] result_q, result_d;
  logic         illegal_q, illegal_d;

  logic [6:0]   major;
  logic [4:0]   rd, rs1, rs2, shamt;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic         is_op, alt, legal;
  logic [N-1:0] opa, opb, imm_i, alu;
  logic signed [N-1:0] opa_s, opb_s, lui_val;
  logic signed [31:0]  lui32;

  assign major  = opcode[6:0];
  assign rd     = opcode[11:7];
  assign funct3 = opcode[14:12];
  assign rs1    = opcode[19:15];
  assign rs2    = opcode[24:20];
  assign funct7 = opcode[31:25];

  assign is_op  = (major == MAJ_OP);
  // funct7 bit 5 selects SUB (register form only) and the arithmetic shifts.
  assign alt    = (funct7 == F7_ALT);

  assign imm_i  = N'($signed(opcode[31:20]));
  assign lui32  = $signed({opcode[31:12], 12'b0});
  assign lui_val = N'(lui32);

  // x0 is never written, but the read is still forced to zero so it cannot
  // depend on the array contents.
  assign opa    = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign opb    = is_op ? ((rs2 == 5'd0) ? '0 : regs_q[rs2]) : imm_i;
  assign opa_s  = $signed(opa);
  assign opb_s  = $signed(opb);
  assign shamt  = opb[4:0];

  always_comb begin
    legal = 1'b0;
    alu   = '0;
    if (major == MAJ_LUI) begin
      legal = 1'b1;
      alu   = $unsigned(lui_val);
    end else if (is_op || major == MAJ_OP_IMM) begin
      // Legality of funct7: register ops need 0000000 except SUB/SRA;
      // immediate ops only constrain funct7 for the shifts.
      if (is_op)
        legal = (funct7 == F7_BASE) || (alt && (funct3 == 3'b000 || funct3 == 3'b101));
      else if (funct3 == 3'b001)
        legal = (funct7 == F7_BASE);
      else if (funct3 == 3'b101)
        legal = (funct7 == F7_BASE) || alt;
      else
        legal = 1'b1;

      case (funct3)
        3'b000:  alu = (is_op && alt) ? opa - opb : opa + opb;
        3'b001:  alu = opa << shamt;
        3'b010:  alu = N'(opa_s < opb_s);
        3'b011:  alu = N'(opa < opb);
        3'b100:  alu = opa ^ opb;
        3'b101:  alu = alt ? $unsigned(opa_s >>> shamt) : opa >> shamt;
        3'b110:  alu = opa | opb;
        default: alu = opa & opb;
      endcase
    end
  end

  always_comb begin
    result_d  = result_q;
    illegal_d = 1'b1;
    if (legal) begin
      result_d  = alu;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
`ifdef REG_SEED_EN
        regs_q[i] <= N'(i);
`else
        regs_q[i] <= '0;
`endif
      end
    end else if (legal && rd != 5'd0) begin
      regs_q[rd] <= alu;
    end
  end

  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_decode.sv
module tb_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] opcode = 32'h0;
  logic [31:0] result;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  // Reference machine state
  logic [31:0] m_regs [32];
  logic [31:0] m_result;
  logic        m_illegal;

  decode #(.N(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .result  (result),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
`ifdef REG_SEED_EN
      m_regs[i] = 32'(i);
`else
      m_regs[i] = 32'h0;
`endif
    end
    m_result  = 32'h0;
    m_illegal = 1'b0;
  endtask

  // Architectural behaviour of one instruction, straight from the ISA rules.
  task automatic model_exec(input logic [31:0] ins);
    logic [6:0]  maj, f7;
    logic [2:0]  f3;
    logic [31:0] a, b, v;
    logic [4:0]  sh;
    bit          reg_form, ok;
    maj = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    reg_form = (maj == 7'b0110011);
    a  = m_regs[ins[19:15]];
    b  = reg_form ? m_regs[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
    sh = b[4:0];
    ok = 1'b0;
    v  = 32'h0;
    if (maj == 7'b0110111) begin
      ok = 1'b1;
      v  = {ins[31:12], 12'h000};
    end else if (reg_form || maj == 7'b0010011) begin
      case (f3)
        3'd0: begin
          if (reg_form && f7 == 7'h20) begin v = a - b; ok = 1'b1; end
          else begin v = a + b; ok = !reg_form || f7 == 7'h00; end
        end
        3'd1: begin v = a << sh; ok = (f7 == 7'h00); end
        3'd2: begin v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; ok = !reg_form || f7 == 7'h00; end
        3'd3: begin v = (a < b) ? 32'd1 : 32'd0; ok = !reg_form || f7 == 7'h00; end
        3'd4: begin v = a ^ b; ok = !reg_form || f7 == 7'h00; end
        3'd5: begin
          if (f7 == 7'h20) v = $signed(a) >>> sh; else v = a >> sh;
          ok = (f7 == 7'h00) || (f7 == 7'h20);
        end
        3'd6: begin v = a | b; ok = !reg_form || f7 == 7'h00; end
        default: begin v = a & b; ok = !reg_form || f7 == 7'h00; end
      endcase
    end
    if (ok) begin
      m_result  = v;
      m_illegal = 1'b0;
      if (ins[11:7] != 5'd0) m_regs[ins[11:7]] = v;
    end else begin
      m_illegal = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] exp_res, input logic exp_ill);
    total++;
    if (result !== exp_res) begin
      bad++;
      $display("FAIL %s result: got %08h expected %08h", name, result, exp_res);
    end
    total++;
    if (illegal !== exp_ill) begin
      bad++;
      $display("FAIL %s illegal: got %0b expected %0b", name, illegal, exp_ill);
    end
  endtask

  // Apply one instruction, let one edge pass, compare with the model.
  task automatic run(input string name, input logic [31:0] ins);
    opcode = ins;
    @(posedge clk); #1;
    model_exec(ins);
    check(name, m_result, m_illegal);
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] exp_res;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [31:0] w, ins;
    logic [6:0]  f7, maj;
    int          sel;

    vecs.push_back('{"addi x1",   i_t(12'd1, 5'd0, 3'd0, 5'd1),        32'h00000001, 1'b0});
    vecs.push_back('{"addi x2",   i_t(12'd2, 5'd0, 3'd0, 5'd2),        32'h00000002, 1'b0});
    vecs.push_back('{"addi x5",   i_t(12'd5, 5'd0, 3'd0, 5'd5),        32'h00000005, 1'b0});
    vecs.push_back('{"add x3",    r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),  32'h00000003, 1'b0});
    vecs.push_back('{"sub x4",    r_t(7'h20, 5'd5, 5'd3, 3'd0, 5'd4),  32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"addi -1",   i_t(12'hFFF, 5'd0, 3'd0, 5'd6),      32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"srai",      i_t(12'h404, 5'd6, 3'd5, 5'd7),      32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"srli",      i_t(12'h01C, 5'd6, 3'd5, 5'd8),      32'h0000000F, 1'b0});
    vecs.push_back('{"sltu",      r_t(7'h00, 5'd6, 5'd0, 3'd3, 5'd9),  32'h00000001, 1'b0});
    vecs.push_back('{"slt",       r_t(7'h00, 5'd0, 5'd6, 3'd2, 5'd10), 32'h00000001, 1'b0});
    vecs.push_back('{"lui",       u_t(20'h12345, 5'd11),               32'h12345000, 1'b0});
    vecs.push_back('{"ori",       i_t(12'h678, 5'd11, 3'd6, 5'd11),    32'h12345678, 1'b0});
    vecs.push_back('{"add x12",   r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd12), 32'h00000003, 1'b0});
    vecs.push_back('{"ill 7F",    32'h0000007F,                        32'h00000003, 1'b1});
    vecs.push_back('{"ill f7",    r_t(7'h01, 5'd2, 5'd1, 3'd0, 5'd12), 32'h00000003, 1'b1});
    vecs.push_back('{"ill slli",  i_t(12'h401, 5'd1, 3'd1, 5'd12),     32'h00000003, 1'b1});
    vecs.push_back('{"add x13",   r_t(7'h00, 5'd12, 5'd11, 3'd0, 5'd13), 32'h1234567B, 1'b0});
    vecs.push_back('{"sll",       r_t(7'h00, 5'd5, 5'd6, 3'd1, 5'd14), 32'hFFFFFFE0, 1'b0});
    vecs.push_back('{"sra",       r_t(7'h20, 5'd2, 5'd4, 3'd5, 5'd15), 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"srl",       r_t(7'h00, 5'd2, 5'd4, 3'd5, 5'd16), 32'h3FFFFFFF, 1'b0});
    vecs.push_back('{"and x0",    r_t(7'h00, 5'd11, 5'd6, 3'd7, 5'd0), 32'h12345678, 1'b0});
    vecs.push_back('{"addi x0",   i_t(12'd5, 5'd0, 3'd0, 5'd0),        32'h00000005, 1'b0});
    vecs.push_back('{"x0 zero",   r_t(7'h00, 5'd1, 5'd0, 3'd0, 5'd17), 32'h00000001, 1'b0});
    vecs.push_back('{"slti",      i_t(12'h000, 5'd6, 3'd2, 5'd18),     32'h00000001, 1'b0});
    vecs.push_back('{"sltiu",     i_t(12'hFFF, 5'd1, 3'd3, 5'd19),     32'h00000001, 1'b0});
    vecs.push_back('{"xori",      i_t(12'h0F0, 5'd6, 3'd4, 5'd20),     32'hFFFFFF0F, 1'b0});
    vecs.push_back('{"andi",      i_t(12'h0FF, 5'd11, 3'd7, 5'd21),    32'h00000078, 1'b0});
    vecs.push_back('{"or x11",    r_t(7'h00, 5'd11, 5'd0, 3'd6, 5'd22), 32'h12345678, 1'b0});

    // Reset state, and edges ignored while rst is high
    #2;
    check("reset", 32'h0, 1'b0);
    opcode = i_t(12'd7, 5'd0, 3'd0, 5'd1);
    @(posedge clk); #1;
    check("edge in reset", 32'h0, 1'b0);
    rst = 1'b0;
    model_reset();

    // First instruction after reset reads x1's reset value
`ifdef REG_SEED_EN
    opcode = r_t(7'h00, 5'd0, 5'd1, 3'd0, 5'd0);
    @(posedge clk); #1;
    model_exec(opcode);
    check("add x0,x1,x0", 32'h00000001, 1'b0);
`else
    opcode = r_t(7'h00, 5'd0, 5'd1, 3'd0, 5'd0);
    @(posedge clk); #1;
    model_exec(opcode);
    check("add x0,x1,x0", 32'h00000000, 1'b0);
`endif
    run("x0 still 0", r_t(7'h00, 5'd0, 5'd0, 3'd0, 5'd0));

    // Directed vectors with hand-computed expectations
    foreach (vecs[k]) begin
      opcode = vecs[k].ins;
      @(posedge clk); #1;
      model_exec(vecs[k].ins);
      check(vecs[k].name, vecs[k].exp_res, vecs[k].exp_ill);
    end

    // Asynchronous reset between edges
    #3;
    rst = 1'b1;
    #1;
    check("async reset", 32'h0, 1'b0);
    opcode = r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    @(posedge clk); #1;
    check("held in reset", 32'h0, 1'b0);
    rst = 1'b0;
    model_reset();
    run("x12 after reset", r_t(7'h00, 5'd0, 5'd12, 3'd0, 5'd0));
    run("x11 after reset", r_t(7'h00, 5'd11, 5'd0, 3'd6, 5'd0));
    run("resume add", r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));

    // Illegal word immediately after reset: result stays 0 from reset value
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    run("ill after reset", 32'hFFFFFFFF);

    // Randomised stream against the reference model
    for (int n = 0; n < 3000; n++) begin
      w   = $urandom();
      sel = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        default: f7 = w[31:25];
      endcase
      if (sel < 4)      maj = 7'b0110011;
      else if (sel < 8) maj = 7'b0010011;
      else if (sel < 9) maj = 7'b0110111;
      else              maj = w[6:0];
      ins = {f7, w[24:7], maj};
      run("random", ins);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
